guess_entry: RTL and testbench

- Keypad-to-number entry stage. Sits between the keypad scanner and the game-control FSM.
- Turns one-hot key codes into a decimal digit buffer that drives the 7-segment path.
- On the enter key, runs a sequential BCD-to-binary conversion and emits the guessed value with a one-cycle valid pulse. The game FSM consumes this pulse as its "guess submitted" event.

---
 rtl/guess_entry.sv | 94 +++++++++
 tb/tb_guess_entry.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/guess_entry.sv
// guess_entry: keypad digit entry buffer with a sequential BCD-to-binary
// conversion launched by the enter key, emitting the result with a one-cycle pulse.
module guess_entry #(
    parameter int NUM_DIGITS = 2,
    parameter int VAL_W = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [11:0]             key_code,
    input  logic                    key_valid,
    input  logic                    clear_in,
    output logic [4*NUM_DIGITS-1:0] digit_bcd,
    output logic [3:0]              digit_count,
    output logic [VAL_W-1:0]        value,
    output logic                    value_valid,
    output logic                    busy
);
    typedef enum logic [1:0] {ENTRY, CONVERT, DONE} state_t;
    state_t state;
    logic kv_d;
    logic [VAL_W-1:0] acc;
    logic [VAL_W-1:0] acc_next;
    logic [2:0] idx;
    logic [3:0] digit;
    logic [3:0] cur_nib;
    logic key_event;
    assign key_event = key_valid & ~kv_d & $onehot(key_code);
    assign cur_nib = digit_bcd[4*idx +: 4];
    // All NUM_DIGITS nibbles are walked MSB first; unused upper nibbles are zero.
    assign acc_next = acc * VAL_W'(10) + {{(VAL_W-4){1'b0}}, cur_nib};
    always_comb begin
        digit = '0;
        for (int i = 0; i < 10; i++)
            if (key_code[i]) digit = 4'(i);
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ENTRY;
            kv_d        <= 1'b0;
            acc         <= '0;
            idx         <= '0;
            digit_bcd   <= '0;
            digit_count <= '0;
            value       <= '0;
            value_valid <= 1'b0;
            busy        <= 1'b0;
        end else begin
            kv_d        <= key_valid;
            value_valid <= 1'b0;
            if (clear_in) begin
                state       <= ENTRY;
                digit_bcd   <= '0;
                digit_count <= '0;
                busy        <= 1'b0;
            end else begin
                case (state)
                    ENTRY: begin
                        if (key_event) begin
                            if (key_code[11]) begin
                                digit_bcd   <= '0;
                                digit_count <= '0;
                            end else if (key_code[10]) begin
                                if (digit_count != 4'd0) begin
                                    state <= CONVERT;
                                    acc   <= '0;
                                    idx   <= 3'(NUM_DIGITS - 1);
                                    busy  <= 1'b1;
                                end
                            end else if (digit_count < 4'(NUM_DIGITS)) begin
                                digit_bcd   <= (digit_bcd << 4) | (4*NUM_DIGITS)'(digit);
                                digit_count <= digit_count + 4'd1;
                            end
                        end
                    end
                    CONVERT: begin
                        acc <= acc_next;
                        idx <= idx - 3'd1;
                        if (idx == 3'd0) begin
                            value       <= acc_next;
                            value_valid <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end
                    end
                    default: begin
                        digit_bcd   <= '0;
                        digit_count <= '0;
                        state       <= ENTRY;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_guess_entry.sv
// tb_guess_entry: directed keypad sequences checked every cycle against a
// digit-queue model, plus hand-computed literal expectations.
module tb_guess_entry;
    localparam int ND = 2;
    localparam int VW = 7;
    logic clk = 0;
    logic rst = 0;
    logic [11:0] key_code = '0;
    logic key_valid = 0;
    logic clear_in = 0;
    logic [4*ND-1:0] digit_bcd;
    logic [3:0] digit_count;
    logic [VW-1:0] value;
    logic value_valid;
    logic busy;
    int n_chk = 0;
    int n_fail = 0;
    int vv_seen = 0;
    int busy_seen = 0;

    guess_entry #(.NUM_DIGITS(ND), .VAL_W(VW)) dut (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid),
        .clear_in(clear_in), .digit_bcd(digit_bcd), .digit_count(digit_count),
        .value(value), .value_valid(value_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Model: the typed digits as a queue, a countdown for the conversion
    // and a one-cycle "done" phase before the buffer empties.
    int mq[$];
    bit m_kv, m_vv, m_done;
    int m_conv, m_val, m_target;

    function automatic int q_decimal();
        int v = 0;
        foreach (mq[i]) v = v * 10 + mq[i];
        return v % (1 << VW);
    endfunction

    function automatic int q_bcd();
        int v = 0;
        foreach (mq[i]) v = (v << 4) | mq[i];
        return v;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_kv = 0; m_vv = 0; m_done = 0; m_conv = 0; m_val = 0;
        end else begin
            bit ev;
            ev = key_valid && !m_kv && $countones(key_code) == 1;
            m_kv = key_valid;
            m_vv = 0;
            if (clear_in) begin
                mq.delete(); m_conv = 0; m_done = 0;
            end else if (m_done) begin
                mq.delete(); m_done = 0;
            end else if (m_conv > 0) begin
                m_conv--;
                if (m_conv == 0) begin
                    m_val = m_target; m_vv = 1; m_done = 1;
                end
            end else if (ev) begin
                if (key_code[11]) mq.delete();
                else if (key_code[10]) begin
                    if (mq.size() > 0) begin
                        m_conv = ND; m_target = q_decimal();
                    end
                end else if (mq.size() < ND) begin
                    for (int i = 0; i < 10; i++) if (key_code[i]) mq.push_back(i);
                end
            end
        end
    end

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model digit_bcd", int'(digit_bcd), q_bcd());
        chk("model digit_count", int'(digit_count), mq.size());
        chk("model value", int'(value), m_val);
        chk("model value_valid", int'(value_valid), int'(m_vv));
        chk("model busy", int'(busy), int'(m_conv > 0));
        if (value_valid) vv_seen++;
        if (busy) busy_seen++;
    end

    task automatic press(int k, int hold);
        @(negedge clk);
        key_code = 12'(1 << k);
        key_valid = 1;
        repeat (hold) @(negedge clk);
        key_valid = 0;
        key_code = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int v0, b0;
        repeat (2) @(negedge clk);
        chk("reset digit_count", int'(digit_count), 0);
        chk("reset value", int'(value), 0);
        rst = 1;
        @(negedge clk);
        // 4, 2, '*' -> 42
        press(4, 5);
        press(2, 5);
        chk("t1 digit_bcd", int'(digit_bcd), 'h42);
        chk("t1 digit_count", int'(digit_count), 2);
        v0 = vv_seen; b0 = busy_seen;
        press(10, 5);
        chk("t1 value", int'(value), 42);
        chk("t1 pulse count", vv_seen - v0, 1);
        chk("t1 busy cycles", busy_seen - b0, 2);
        chk("t1 buffer cleared", int'(digit_bcd), 0);
        // long hold gives a single event
        press(7, 20);
        chk("t2 digit_count", int'(digit_count), 1);
        chk("t2 digit_bcd", int'(digit_bcd), 'h07);
        press(11, 1);
        // overflow digit dropped
        press(1, 2); press(2, 2); press(3, 2);
        chk("t3 digit_bcd", int'(digit_bcd), 'h12);
        press(10, 2);
        chk("t3 value", int'(value), 12);
        // clear then enter on empty buffer
        v0 = vv_seen;
        press(9, 2); press(11, 2);
        chk("t4 cleared count", int'(digit_count), 0);
        press(10, 2);
        chk("t4 no pulse", vv_seen - v0, 0);
        chk("t4 value kept", int'(value), 12);
        press(0, 2); press(5, 2);
        chk("t4 leading zero bcd", int'(digit_bcd), 'h05);
        chk("t4 leading zero count", int'(digit_count), 2);
        press(10, 2);
        chk("t4 value", int'(value), 5);
        // clear_in aborts a conversion
        press(8, 2); press(8, 2);
        v0 = vv_seen;
        @(negedge clk);
        key_code = 12'h400; key_valid = 1;
        @(negedge clk);
        clear_in = 1;
        @(negedge clk);
        clear_in = 0; key_valid = 0; key_code = '0;
        repeat (4) @(negedge clk);
        chk("t5 no pulse", vv_seen - v0, 0);
        chk("t5 busy", int'(busy), 0);
        chk("t5 digit_count", int'(digit_count), 0);
        chk("t5 value kept", int'(value), 5);
        // non-one-hot key ignored
        press(3, 2);
        @(negedge clk);
        key_code = 12'h003; key_valid = 1;
        @(negedge clk);
        key_valid = 0; key_code = '0;
        repeat (2) @(negedge clk);
        chk("t6 multi-hot count", int'(digit_count), 1);
        chk("t6 multi-hot bcd", int'(digit_bcd), 'h03);
        press(6, 2);
        chk("t6 digit_bcd", int'(digit_bcd), 'h36);
        // async reset mid-conversion
        v0 = vv_seen;
        @(negedge clk);
        key_code = 12'h400; key_valid = 1;
        @(negedge clk);
        #1 rst = 0;
        #1;
        chk("t6 rst busy", int'(busy), 0);
        chk("t6 rst value", int'(value), 0);
        chk("t6 rst digit_count", int'(digit_count), 0);
        chk("t6 rst digit_bcd", int'(digit_bcd), 0);
        key_valid = 0; key_code = '0;
        repeat (3) @(negedge clk);
        chk("t6 rst no pulse", vv_seen - v0, 0);
        rst = 1;
        press(2, 2);
        press(10, 2);
        chk("t7 value after reset", int'(value), 2);
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
